ula_sched: RTL

Scheduler that shares the single registered ALU (`ula`) among `NREQ` requesters. It arbitrates round-robin and latches the granted request's selector and operands. It drives the ALU and captures its registered result one cycle later. The result is returned to the requester through a valid/ready response channel. It sits between the requesting blocks and the `ula` instance, and is the only driver of the ALU's `Sel`, `A` and `B` inputs.

---
 rtl/ula_pkg.sv | 31 +++
 rtl/ula_rr_arb.sv | 31 +++
 rtl/ula_sched.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ALU scheduler: opcodes, widths and FSM states.
package ula_pkg;

    localparam int unsigned SEL_W  = 4;
    localparam int unsigned DATA_W = 8;

    localparam logic [SEL_W-1:0] OP_SOMA  = 4'b0000;
    localparam logic [SEL_W-1:0] OP_SUB   = 4'b0001;
    localparam logic [SEL_W-1:0] OP_MULT  = 4'b0010;
    localparam logic [SEL_W-1:0] OP_DIV   = 4'b0011;
    localparam logic [SEL_W-1:0] OP_MOD   = 4'b0100;
    localparam logic [SEL_W-1:0] OP_AND   = 4'b0101;
    localparam logic [SEL_W-1:0] OP_OR    = 4'b0110;
    localparam logic [SEL_W-1:0] OP_XOR   = 4'b0111;
    localparam logic [SEL_W-1:0] OP_NOT   = 4'b1000;
    localparam logic [SEL_W-1:0] OP_SHL   = 4'b1001;
    localparam logic [SEL_W-1:0] OP_SHR   = 4'b1010;
    localparam logic [SEL_W-1:0] OP_ROL   = 4'b1011;
    localparam logic [SEL_W-1:0] OP_ROR   = 4'b1100;
    localparam logic [SEL_W-1:0] OP_MAIOR = 4'b1101;
    localparam logic [SEL_W-1:0] OP_MENOR = 4'b1110;
    localparam logic [SEL_W-1:0] OP_IGUAL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/ula_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr_i, circularly.
module ula_rr_arb #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_idx_o,
    output logic            gnt_valid_o
);

    logic [31:0] pos;

    // Scan from the pointer and keep only the first hit.
    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        pos         = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = (32'(ptr_i) + k) % NREQ;
            if (!gnt_valid_o && req_i[pos[IDW-1:0]]) begin
                gnt_valid_o           = 1'b1;
                gnt_idx_o             = pos[IDW-1:0];
                gnt_o[pos[IDW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ula_sched.sv
// Round-robin scheduler sharing one registered ALU among NREQ requesters.
// Optional macro ULA_SCHED_DIV0_CHK_EN: answer divide-by-zero locally with
// data 8'hFF and rsp_err=1 instead of issuing it to the ALU.
module ula_sched
    import ula_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [SEL_W*NREQ-1:0]  req_sel,
    input  logic [DATA_W*NREQ-1:0] req_a,
    input  logic [DATA_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]        ack,
    output logic [SEL_W-1:0]       ula_sel,
    output logic [DATA_W-1:0]      ula_a,
    output logic [DATA_W-1:0]      ula_b,
    input  logic [DATA_W-1:0]      ula_saida,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [15:0]            op_count
);

    state_e              state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [15:0]         cnt_q, cnt_d;
`ifdef ULA_SCHED_DIV0_CHK_EN
    logic                err_q, err_d;
`endif

    logic [NREQ-1:0]     gnt;
    logic [IDW-1:0]      gnt_idx;
    logic                gnt_valid;

    ula_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // Next-state, latch and ack logic; ack is held low while reset is asserted.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ack     = '0;
`ifdef ULA_SCHED_DIV0_CHK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid && !rst) begin
                    ack     = gnt;
                    id_d    = gnt_idx;
                    sel_d   = req_sel[gnt_idx*SEL_W +: SEL_W];
                    a_d     = req_a[gnt_idx*DATA_W +: DATA_W];
                    b_d     = req_b[gnt_idx*DATA_W +: DATA_W];
                    ptr_d   = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
                    state_d = ST_ISSUE;
`ifdef ULA_SCHED_DIV0_CHK_EN
                    err_d   = 1'b0;
                    if (sel_d == OP_DIV && b_d == '0) begin
                        data_d  = '1;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
`endif
                end
            end
            ST_ISSUE: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                data_d  = ula_saida;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched-operand registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
`ifdef ULA_SCHED_DIV0_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
`ifdef ULA_SCHED_DIV0_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign ula_sel   = sel_q;
    assign ula_a     = a_q;
    assign ula_b     = b_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign busy      = (state_q != ST_IDLE);
    assign op_count  = cnt_q;
`ifdef ULA_SCHED_DIV0_CHK_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
